panda_register_file_mp: RTL and testbench

// - Multi-ported integer register file with a built-in busy-bit scoreboard, successor to the 2R/1W file.
// - NumRead combinational read ports, NumWrite synchronous write ports, per-register busy tracking
//   for in-flight producers; sits between decode (read/alloc) and writeback (write/clear) in the core.

---
 rtl/panda_register_file_mp.sv | 101 ++++++++++
 tb/tb_panda_register_file_mp.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/panda_register_file_mp.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : panda_register_file_mp                                      |
// | Description: Multi-ported integer register file with busy-bit scoreboard.|
// |              Optional same-cycle write forwarding: PANDA_RF_BYPASS_EN.   |
// | Revision   : 1.0                                                          |
// +--------------------------------------------------------------------------+
module panda_register_file_mp #(
  parameter int Width    = 32,
  parameter int Depth    = 32,
  parameter int NumRead  = 2,
  parameter int NumWrite = 2,
  parameter int ZeroReg  = 1,
  localparam int AW      = $clog2(Depth)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NumRead*AW-1:0]     rs_addr_i,
  output logic [NumRead*Width-1:0]  rs_data_o,
  output logic [NumRead-1:0]        rs_busy_o,
  input  logic [NumWrite*AW-1:0]    rd_addr_i,
  input  logic [NumWrite*Width-1:0] rd_data_i,
  input  logic [NumWrite-1:0]       rd_we_i,
  input  logic [AW-1:0]             alloc_addr_i,
  input  logic                      alloc_valid_i,
  output logic                      alloc_ready_o,
  input  logic                      flush_i
);

  logic [Width-1:0] regs_q [Depth];
  logic [Width-1:0] regs_d [Depth];
  logic [Depth-1:0] busy_q;
  logic [Depth-1:0] busy_d;

  function automatic logic is_zero_reg(input logic [AW-1:0] addr);
    return (ZeroReg != 0) && (addr == '0);
  endfunction

  assign alloc_ready_o = alloc_valid_i & ~busy_q[alloc_addr_i] & ~flush_i & ~rst_i;

  // Ascending port order lets the highest-index write win on address collisions.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int k = 0; k < NumWrite; k++) begin
      if (rd_we_i[k] && !is_zero_reg(rd_addr_i[k*AW +: AW])) begin
        regs_d[rd_addr_i[k*AW +: AW]] = rd_data_i[k*Width +: Width];
        busy_d[rd_addr_i[k*AW +: AW]] = 1'b0;
      end
    end
    if (alloc_ready_o && !is_zero_reg(alloc_addr_i)) begin
      busy_d[alloc_addr_i] = 1'b1;
    end
    if (flush_i) begin
      busy_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < Depth; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  for (genvar p = 0; p < NumRead; p++) begin : g_read
    logic [AW-1:0]    rd_addr;
    logic [Width-1:0] rd_val;
    logic             rd_busy;

    assign rd_addr = rs_addr_i[p*AW +: AW];

    always_comb begin
      rd_val  = regs_q[rd_addr];
      rd_busy = busy_q[rd_addr];
      if (is_zero_reg(rd_addr)) begin
        rd_val  = '0;
        rd_busy = 1'b0;
      end
`ifdef PANDA_RF_BYPASS_EN
      for (int k = 0; k < NumWrite; k++) begin
        if (rd_we_i[k] && (rd_addr_i[k*AW +: AW] == rd_addr) && !is_zero_reg(rd_addr)) begin
          rd_val  = rd_data_i[k*Width +: Width];
          rd_busy = 1'b0;
        end
      end
`else
`endif
    end

    assign rs_data_o[p*Width +: Width] = rd_val;
    assign rs_busy_o[p]                = rd_busy;
  end

endmodule
`default_nettype wire

// File: tb/tb_panda_register_file_mp.sv
`default_nettype none
// Directed table-driven bench for panda_register_file_mp (default parameters).
module tb_panda_register_file_mp;

  localparam int W  = 32;
  localparam int AW = 5;
`ifdef PANDA_RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [2*AW-1:0] rs_addr;
  logic [2*W-1:0]  rs_data;
  logic [1:0]      rs_busy;
  logic [2*AW-1:0] rd_addr;
  logic [2*W-1:0]  rd_data;
  logic [1:0]      rd_we;
  logic [AW-1:0]   alloc_addr;
  logic            alloc_valid;
  logic            alloc_ready;
  logic            flush;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  panda_register_file_mp dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .rs_addr_i    (rs_addr),
    .rs_data_o    (rs_data),
    .rs_busy_o    (rs_busy),
    .rd_addr_i    (rd_addr),
    .rd_data_i    (rd_data),
    .rd_we_i      (rd_we),
    .alloc_addr_i (alloc_addr),
    .alloc_valid_i(alloc_valid),
    .alloc_ready_o(alloc_ready),
    .flush_i      (flush)
  );

  typedef struct {
    logic [AW-1:0] ra0, ra1;
    logic [1:0]    we;
    logic [AW-1:0] wa0, wa1;
    logic [W-1:0]  wd0, wd1;
    logic [AW-1:0] aa;
    logic          av, fl;
    logic [W-1:0]  ed0, ed1;
    logic          eb0, eb1, erdy;
  } vec_t;

  localparam int NV = 16;
  vec_t vec [NV];

  function automatic vec_t mk(
    input logic [AW-1:0] ra0, ra1, input logic [1:0] we,
    input logic [AW-1:0] wa0, wa1, input logic [W-1:0] wd0, wd1,
    input logic [AW-1:0] aa, input logic av, fl,
    input logic [W-1:0] ed0, input logic eb0,
    input logic [W-1:0] ed1, input logic eb1, input logic erdy);
    vec_t v;
    v.ra0 = ra0; v.ra1 = ra1; v.we = we; v.wa0 = wa0; v.wa1 = wa1;
    v.wd0 = wd0; v.wd1 = wd1; v.aa = aa; v.av = av; v.fl = fl;
    v.ed0 = ed0; v.eb0 = eb0; v.ed1 = ed1; v.eb1 = eb1; v.erdy = erdy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_we = 2'b00; rd_addr = '0; rd_data = '0;
    alloc_valid = 1'b0; alloc_addr = '0; flush = 1'b0;
  endtask

  initial begin
    // ra0 ra1 we wa0 wa1 wd0 wd1 aa av fl | ed0 eb0 ed1 eb1 rdy
    vec[0]  = mk(5, 0, 2'b11, 5, 5, 32'hAAAA_0000, 32'h5555_1111, 0, 0, 0,
                 BYP ? 32'h5555_1111 : 32'h0, 0, 0, 0, 0);
    vec[1]  = mk(5, 0, 2'b01, 0, 0, 32'hDEAD_BEEF, 0, 0, 0, 0,
                 32'h5555_1111, 0, 0, 0, 0);
    vec[2]  = mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    vec[3]  = mk(0, 7, 2'b00, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 1);
    vec[4]  = mk(7, 0, 2'b00, 0, 0, 0, 0, 7, 1, 0, 0, 1, 0, 0, 0);
    vec[5]  = mk(7, 0, 2'b10, 0, 7, 0, 32'h1234, 0, 0, 0,
                 BYP ? 32'h1234 : 32'h0, !BYP, 0, 0, 0);
    vec[6]  = mk(7, 0, 2'b00, 0, 0, 0, 0, 3, 1, 0, 32'h1234, 0, 0, 0, 1);
    vec[7]  = mk(3, 0, 2'b00, 0, 0, 0, 0, 9, 1, 0, 0, 1, 0, 0, 1);
    vec[8]  = mk(9, 3, 2'b01, 3, 0, 32'hCAFE, 0, 12, 1, 1,
                 0, 1, BYP ? 32'hCAFE : 32'h0, BYP ? 1'b0 : 1'b1, 0);
    vec[9]  = mk(3, 9, 2'b00, 0, 0, 0, 0, 0, 0, 0, 32'hCAFE, 0, 0, 0, 0);
    vec[10] = mk(12, 3, 2'b01, 12, 0, 32'h0F0F_0F0F, 0, 0, 0, 0,
                 BYP ? 32'h0F0F_0F0F : 32'h0, 0, 32'hCAFE, 0, 0);
    vec[11] = mk(12, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 32'h0F0F_0F0F, 0, 0, 0, 0);
    vec[12] = mk(20, 0, 2'b01, 20, 0, 32'hBEEF, 0, 20, 1, 0,
                 BYP ? 32'hBEEF : 32'h0, 0, 0, 0, 1);
    vec[13] = mk(20, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 32'hBEEF, 1, 0, 0, 0);
    vec[14] = mk(20, 21, 2'b11, 21, 20, 32'h88, 32'h77, 20, 1, 0,
                 BYP ? 32'h77 : 32'hBEEF, !BYP, BYP ? 32'h88 : 32'h0, 0, 0);
    vec[15] = mk(20, 21, 2'b00, 0, 0, 0, 0, 0, 0, 0, 32'h77, 0, 32'h88, 0, 0);

    rst = 1'b1; rs_addr = '0; idle();
    tick(); tick();
    rst = 1'b0;

    // Dirty the state, then reset while writes and an alloc are still requested.
    for (int i = 0; i < 4; i++) begin
      rd_we = 2'b11;
      rd_addr = {AW'($urandom_range(1, 31)), AW'($urandom_range(1, 31))};
      rd_data = {$urandom, $urandom};
      alloc_valid = 1'b1;
      alloc_addr = AW'($urandom_range(1, 31));
      tick();
    end
    rst = 1'b1;
    alloc_addr = 5'd4;
    @(negedge clk);
    chk("ready_in_reset", 32'(alloc_ready), 32'h0);
    tick();
    rst = 1'b0; idle();
    for (int a = 0; a < 32; a++) begin
      rs_addr = {AW'(31 - a), AW'(a)};
      #1;
      chk($sformatf("rst_data_p0[%0d]", a), rs_data[W-1:0], 32'h0);
      chk($sformatf("rst_data_p1[%0d]", 31 - a), rs_data[2*W-1:W], 32'h0);
      chk($sformatf("rst_busy[%0d]", a), 32'(rs_busy), 32'h0);
    end

    for (int i = 0; i < NV; i++) begin
      rs_addr = {vec[i].ra1, vec[i].ra0};
      rd_we = vec[i].we;
      rd_addr = {vec[i].wa1, vec[i].wa0};
      rd_data = {vec[i].wd1, vec[i].wd0};
      alloc_addr = vec[i].aa;
      alloc_valid = vec[i].av;
      flush = vec[i].fl;
      @(negedge clk);
      chk($sformatf("v%0d_data0", i), rs_data[W-1:0], vec[i].ed0);
      chk($sformatf("v%0d_busy0", i), 32'(rs_busy[0]), 32'(vec[i].eb0));
      chk($sformatf("v%0d_data1", i), rs_data[2*W-1:W], vec[i].ed1);
      chk($sformatf("v%0d_busy1", i), 32'(rs_busy[1]), 32'(vec[i].eb1));
      chk($sformatf("v%0d_ready", i), 32'(alloc_ready), 32'(vec[i].erdy));
      tick();
    end
    idle();

    // Flush wipes several pending producers at once, alloc refused meanwhile.
    alloc_valid = 1'b1; alloc_addr = 5'd10; tick();
    alloc_addr = 5'd11; tick();
    alloc_valid = 1'b0; rs_addr = {5'd11, 5'd10};
    #1;
    chk("pre_flush_busy", 32'(rs_busy), 32'h3);
    flush = 1'b1; alloc_valid = 1'b1; alloc_addr = 5'd13;
    @(negedge clk);
    chk("flush_ready", 32'(alloc_ready), 32'h0);
    tick();
    flush = 1'b0; alloc_valid = 1'b0;
    rs_addr = {5'd13, 5'd10};
    #1;
    chk("post_flush_busy", 32'(rs_busy), 32'h0);
    rs_addr = {5'd0, 5'd11};
    #1;
    chk("post_flush_busy11", 32'(rs_busy), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
